uart_rx_sipo: RTL

Receive-side serial-in/parallel-out stage of the full-duplex UART core. It sits directly downstream of the transmit line and consumes the frames the transmitter produces: 1 start bit, 8 data bits LSB-first, 1 parity bit, 1 stop bit. It oversamples the asynchronous `rx` pin, validates start, parity and stop bits, and presents each received byte with a one-cycle `valid` pulse and error flags.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_sipo.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to transmitter and receiver),
// frame width and parity mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DATA_BITS = 8;

    localparam bit PARITY_MODE_EVEN = 1'b0;
    localparam bit PARITY_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input, with a selectable reset value
// so idle-high lines do not produce a spurious edge when reset is released.
module uart_rx_sync #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= RESET_VAL;
            sync_out <= RESET_VAL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receiver: oversamples rx, checks start/parity/stop and presents each byte
// with a one-cycle valid pulse plus parity and framing error flags.
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = PARITY_MODE_EVEN
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_d;
    uart_state_t          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_bit_n;
    logic [7:0]           data_out_n;
    logic                 valid_n;
    logic                 parity_err_n;
    logic                 frame_err_n;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk      (baud_clk),
        .rst      (rst),
        .async_in (rx),
        .sync_out (rx_s)
    );

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            rx_d <= 1'b1;
        end else begin
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            par_bit    <= par_bit_n;
            data_out   <= data_out_n;
            valid      <= valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
            busy       <= (state_n != IDLE);
        end
    end

    // Start is re-checked mid-bit; every later bit is sampled one full period on,
    // which keeps all samples centred. STOP exits at mid-bit to catch a back-to-back start.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        par_bit_n    = par_bit;
        data_out_n   = data_out;
        valid_n      = 1'b0;
        parity_err_n = parity_err;
        frame_err_n  = frame_err;

        case (state)
            IDLE: begin
                if (en && !rx_s && rx_d) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_n = PARITY;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    par_bit_n = rx_s;
                    state_n   = STOP;
                end
            end
            STOP: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    cnt_n        = '0;
                    state_n      = IDLE;
                    data_out_n   = shreg;
                    valid_n      = 1'b1;
                    parity_err_n = (^shreg) ^ par_bit ^ PARITY_ODD;
                    frame_err_n  = ~rx_s;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule
